// File: rtl/matrix_register_bank_pkg.sv
// rtl/matrix_register_bank_pkg.sv - request type, matrix select and FSM state encodings
// Shared with square_matrix_mult so both ends of the register-request bus agree.
package matrix_register_bank_pkg;
    localparam logic [1:0] TYPE_CELL = 2'b00;
    localparam logic [1:0] TYPE_ROW  = 2'b01;
    localparam logic [1:0] TYPE_COL  = 2'b10;

    localparam logic [1:0] MAT_A = 2'b00;
    localparam logic [1:0] MAT_B = 2'b01;
    localparam logic [1:0] MAT_C = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_RESP   = 2'd2
    } bank_state_e;

    function automatic logic mat_legal(input logic [1:0] m);
        return m != 2'b11;
    endfunction
endpackage

// File: rtl/matrix_register_bank_store.sv
// rtl/matrix_register_bank_store.sv - one matrix: single write port, two combinational read ports
// Contents are deliberately not reset; out-of-range reads return 0 and out-of-range writes are dropped.
module matrix_store
    import matrix_register_bank_pkg::*;
#(
    parameter int depth         = 4,
    parameter int cell_width    = 8,
    parameter int address_width = 2
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [address_width-1:0] wr_addr,
    input  logic [cell_width-1:0]    wr_data,
    input  logic [address_width-1:0] gather_addr,
    output logic [cell_width-1:0]    gather_data,
    input  logic [address_width-1:0] host_addr,
    output logic [cell_width-1:0]    host_data
);
    logic [cell_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < depth)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        gather_data = '0;
        host_data   = '0;
        if (32'(gather_addr) < depth) gather_data = mem_q[gather_addr];
        if (32'(host_addr) < depth)   host_data   = mem_q[host_addr];
    end
endmodule

// File: rtl/matrix_register_bank.sv
// rtl/matrix_register_bank.sv - A/B/C register bank serving cell/row/column reads and a host side-port
// Row/column reads gather one lane per cycle into a private buffer so out_data only changes on a response.
module matrix_register_bank
    import matrix_register_bank_pkg::*;
#(
    parameter int size          = 4,
    parameter int cell_width    = 16,
    parameter int address_width = 4,
    localparam int width        = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic [address_width-1:0] in_reg_address,
    input  logic [1:0]               in_type,
    input  logic [1:0]               in_matrix,
    input  logic                     in_read_en,
    input  logic                     in_write_en,
    input  logic [width-1:0]         in_write_data,
    output logic [width-1:0]         out_data,
    output logic                     out_data_ready,
    input  logic                     host_wr_en,
    input  logic                     host_rd_en,
    input  logic [1:0]               host_matrix,
    input  logic [address_width-1:0] host_addr,
    input  logic [cell_width-1:0]    host_wr_data,
    output logic [cell_width-1:0]    host_rd_data
);
    localparam int depth     = size * size;
    localparam int cnt_width = $clog2(size);

    bank_state_e              state_q, state_d;
    logic [cnt_width-1:0]     cnt_q, cnt_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [1:0]               type_q, type_d, mat_q, mat_d;
    logic [width-1:0]         gather_q, gather_d, data_q, data_d;
    logic [cell_width-1:0]    host_rd_q, host_rd_d;

    logic [cell_width-1:0]    gather_cell [3];
    logic [cell_width-1:0]    host_cell [3];
    logic [cell_width-1:0]    rd_cell;
    logic [address_width-1:0] rd_addr;
    logic [1:0]               rd_mat;
    logic                     rd_in_range;
    logic [31:0]              lane_idx;
    logic                     req_wr_ok;
    logic                     unused_wr_hi;

    assign req_wr_ok    = in_write_en && (in_type == TYPE_CELL) && mat_legal(in_matrix);
    assign unused_wr_hi = ^in_write_data[width-1:cell_width];

    // Each store has one write port: the requester takes it when both target the same matrix.
    for (genvar g = 0; g < 3; g++) begin : g_store
        logic req_hit, host_hit;
        assign req_hit  = req_wr_ok && (in_matrix == 2'(g));
        assign host_hit = host_wr_en && (host_matrix == 2'(g));

        matrix_store #(
            .depth        (depth),
            .cell_width   (cell_width),
            .address_width(address_width)
        ) u_store (
            .clk        (in_clk),
            .wr_en      (req_hit || host_hit),
            .wr_addr    (req_hit ? in_reg_address : host_addr),
            .wr_data    (req_hit ? in_write_data[cell_width-1:0] : host_wr_data),
            .gather_addr(rd_addr),
            .gather_data(gather_cell[g]),
            .host_addr  (host_addr),
            .host_data  (host_cell[g])
        );
    end

    always_comb begin
        lane_idx = 32'(addr_q) + ((type_q == TYPE_COL) ? 32'(cnt_q) * 32'(size) : 32'(cnt_q));
        if (state_q == ST_IDLE) begin
            rd_addr     = in_reg_address;
            rd_mat      = in_matrix;
            rd_in_range = 32'(in_reg_address) < depth;
        end else begin
            rd_addr     = lane_idx[address_width-1:0];
            rd_mat      = mat_q;
            rd_in_range = lane_idx < depth;
        end
        rd_cell = '0;
        if (rd_in_range) begin
            case (rd_mat)
                MAT_A:   rd_cell = gather_cell[0];
                MAT_B:   rd_cell = gather_cell[1];
                MAT_C:   rd_cell = gather_cell[2];
                default: rd_cell = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        type_d   = type_q;
        mat_d    = mat_q;
        gather_d = gather_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_read_en) begin
                    addr_d = in_reg_address;
                    type_d = in_type;
                    mat_d  = in_matrix;
                    cnt_d  = '0;
                    if (mat_legal(in_matrix) && (32'(in_reg_address) < depth) &&
                        ((in_type == TYPE_ROW) || (in_type == TYPE_COL))) begin
                        state_d = ST_GATHER;
                    end else begin
                        state_d = ST_RESP;
                        data_d  = (mat_legal(in_matrix) && (32'(in_reg_address) < depth) &&
                                   (in_type == TYPE_CELL)) ? width'(rd_cell) : '0;
                    end
                end
            end
            ST_GATHER: begin
                gather_d[cnt_q*cell_width +: cell_width] = rd_cell;
                if (cnt_q == cnt_width'(size - 1)) begin
                    state_d = ST_RESP;
                    data_d  = gather_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        host_rd_d = host_rd_q;
        if (host_rd_en) begin
            case (host_matrix)
                MAT_A:   host_rd_d = host_cell[0];
                MAT_B:   host_rd_d = host_cell[1];
                MAT_C:   host_rd_d = host_cell[2];
                default: host_rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            type_q    <= '0;
            mat_q     <= '0;
            gather_q  <= '0;
            data_q    <= '0;
            host_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            mat_q     <= mat_d;
            gather_q  <= gather_d;
            data_q    <= data_d;
            host_rd_q <= host_rd_d;
        end
    end

    assign out_data       = data_q;
    assign out_data_ready = (state_q == ST_RESP);
    assign host_rd_data   = host_rd_q;
endmodule

// File: tb/tb_matrix_register_bank.sv
// tb/tb_matrix_register_bank.sv - directed plus random checks of matrix_register_bank against a flat-array model
module tb_matrix_register_bank;
    import matrix_register_bank_pkg::*;

    localparam int SIZE  = 2;
    localparam int CW    = 8;
    localparam int AW    = 2;
    localparam int W     = CW * SIZE;
    localparam int DEPTH = SIZE * SIZE;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] in_reg_address;
    logic [1:0]    in_type, in_matrix;
    logic          in_read_en, in_write_en;
    logic [W-1:0]  in_write_data;
    logic [W-1:0]  out_data;
    logic          out_data_ready;
    logic          host_wr_en, host_rd_en;
    logic [1:0]    host_matrix;
    logic [AW-1:0] host_addr;
    logic [CW-1:0] host_wr_data, host_rd_data;

    int vectors = 0;
    int miscompares = 0;
    logic [CW-1:0] model [3][DEPTH];
    logic [W-1:0]  exp_w;
    logic [CW-1:0] exp_c;

    always #5 clk = ~clk;

    matrix_register_bank #(.size(SIZE), .cell_width(CW), .address_width(AW)) dut (
        .in_clk(clk), .in_reset(rst), .in_reg_address(in_reg_address), .in_type(in_type),
        .in_matrix(in_matrix), .in_read_en(in_read_en), .in_write_en(in_write_en),
        .in_write_data(in_write_data), .out_data(out_data), .out_data_ready(out_data_ready),
        .host_wr_en(host_wr_en), .host_rd_en(host_rd_en), .host_matrix(host_matrix),
        .host_addr(host_addr), .host_wr_data(host_wr_data), .host_rd_data(host_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_resp(input logic [1:0] t, input logic [1:0] m, input int a);
        logic [W-1:0] r = '0;
        if (t == 2'b11 || m == 2'b11 || a >= DEPTH) return '0;
        if (t == TYPE_CELL) return W'(model[m][a]);
        for (int i = 0; i < SIZE; i++) begin
            int idx = (t == TYPE_ROW) ? a + i : a + i * SIZE;
            if (idx < DEPTH) r[i*CW +: CW] = model[m][idx];
        end
        return r;
    endfunction

    task automatic host_write(input logic [1:0] m, input int a, input logic [CW-1:0] d);
        @(negedge clk);
        host_wr_en = 1'b1; host_matrix = m; host_addr = AW'(a); host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
        if (m != 2'b11) model[m][a] = d;
    endtask

    task automatic req_write(input logic [1:0] t, input logic [1:0] m, input int a, input logic [CW-1:0] d);
        @(negedge clk);
        in_write_en = 1'b1; in_type = t; in_matrix = m; in_reg_address = AW'(a);
        in_write_data = {8'($urandom), d};
        @(negedge clk);
        in_write_en = 1'b0;
        if (t == TYPE_CELL && m != 2'b11) model[m][a] = d;
    endtask

    task automatic host_read(input logic [1:0] m, input int a, input string tag);
        @(negedge clk);
        host_rd_en = 1'b1; host_matrix = m; host_addr = AW'(a);
        @(negedge clk);
        host_rd_en = 1'b0;
        check(tag, 32'(host_rd_data), (m == 2'b11) ? 32'd0 : 32'(model[m][a]));
    endtask

    task automatic request(input logic [1:0] t, input logic [1:0] m, input int a, input string tag);
        int lat = 0;
        int exp_lat;
        logic [W-1:0] exp_d;
        exp_d   = model_resp(t, m, a);
        exp_lat = (t != 2'b11 && m != 2'b11 && a < DEPTH && t != TYPE_CELL) ? SIZE + 1 : 1;
        @(negedge clk);
        in_read_en = 1'b1; in_type = t; in_matrix = m; in_reg_address = AW'(a);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_data_ready && lat < 20);
        in_read_en = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(out_data_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_reg_address = '0; in_type = '0; in_matrix = '0; in_read_en = 1'b0;
        in_write_en = 1'b0; in_write_data = '0;
        host_wr_en = 1'b0; host_rd_en = 1'b0; host_matrix = '0; host_addr = '0; host_wr_data = '0;
        #1;
        check("reset_ready", 32'(out_data_ready), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_host_rd", 32'(host_rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            host_write(MAT_A, i, CW'(i + 1));
            host_write(MAT_B, i, CW'(i + 5));
            host_write(MAT_C, i, 8'h00);
        end

        request(TYPE_ROW, MAT_A, 2, "t1_row_a2");
        check("t1_const", 32'(out_data), 32'h0403);
        request(TYPE_COL, MAT_B, 1, "t2_col_b1");
        check("t2_const", 32'(out_data), 32'h0806);
        request(TYPE_CELL, MAT_B, 2, "cell_b2");

        // Writes landing mid-gather: C3 is unrelated, B1 is an already gathered lane
        exp_w = model_resp(TYPE_COL, MAT_B, 1);
        @(negedge clk);
        in_read_en = 1'b1; in_type = TYPE_COL; in_matrix = MAT_B; in_reg_address = 2'd1;
        @(negedge clk);
        in_write_en = 1'b1; in_type = TYPE_CELL; in_matrix = MAT_C; in_reg_address = 2'd3;
        in_write_data = 16'h00AA;
        @(negedge clk);
        in_matrix = MAT_B; in_reg_address = 2'd1; in_write_data = 16'h0055;
        @(negedge clk);
        in_write_en = 1'b0;
        check("t3_ready", 32'(out_data_ready), 32'd1);
        check("t3_data", 32'(out_data), 32'(exp_w));
        in_read_en = 1'b0;
        model[MAT_C][3] = 8'hAA;
        model[MAT_B][1] = 8'h55;
        @(negedge clk);
        check("t3_pulse", 32'(out_data_ready), 32'd0);
        host_read(MAT_C, 3, "t3_host_c3");
        check("t3_host_const", 32'(host_rd_data), 32'hAA);
        @(negedge clk);
        check("host_rd_held", 32'(host_rd_data), 32'hAA);
        host_read(MAT_B, 1, "t3_host_b1");

        request(2'b11, MAT_A, 0, "t4_type11");
        request(TYPE_ROW, 2'b11, 0, "t4_mat11");
        req_write(TYPE_ROW, MAT_C, 1, 8'h5A);
        host_read(MAT_C, 1, "t4_c1_unchanged");
        req_write(TYPE_CELL, 2'b11, 2, 8'h3C);
        host_read(MAT_A, 2, "t4_a2_unchanged");
        host_read(MAT_B, 2, "t4_b2_unchanged");
        host_read(MAT_C, 2, "t4_c2_unchanged");
        host_read(2'b11, 0, "t4_host_mat11");

        // Requester write and cell read of the same address in one IDLE cycle
        exp_w = model_resp(TYPE_CELL, MAT_A, 1);
        @(negedge clk);
        in_read_en = 1'b1; in_write_en = 1'b1; in_type = TYPE_CELL; in_matrix = MAT_A;
        in_reg_address = 2'd1; in_write_data = 16'h0077;
        @(negedge clk);
        in_write_en = 1'b0;
        check("rw_same_ready", 32'(out_data_ready), 32'd1);
        check("rw_same_data", 32'(out_data), 32'(exp_w));
        in_read_en = 1'b0;
        model[MAT_A][1] = 8'h77;
        host_read(MAT_A, 1, "rw_same_after");

        exp_c = model[MAT_B][2];
        @(negedge clk);
        host_wr_en = 1'b1; host_rd_en = 1'b1; host_matrix = MAT_B; host_addr = 2'd2; host_wr_data = 8'h99;
        @(negedge clk);
        host_wr_en = 1'b0; host_rd_en = 1'b0;
        check("host_rw_prewrite", 32'(host_rd_data), 32'(exp_c));
        model[MAT_B][2] = 8'h99;
        host_read(MAT_B, 2, "host_rw_after");

        @(negedge clk);
        in_write_en = 1'b1; in_type = TYPE_CELL; in_matrix = MAT_C; in_reg_address = 2'd0;
        in_write_data = 16'h0011;
        host_wr_en = 1'b1; host_matrix = MAT_C; host_addr = 2'd0; host_wr_data = 8'h22;
        @(negedge clk);
        in_write_en = 1'b0; host_wr_en = 1'b0;
        model[MAT_C][0] = 8'h11;
        host_read(MAT_C, 0, "req_beats_host");

        // Asynchronous reset in the middle of a row gather
        request(TYPE_CELL, MAT_A, 3, "t5_pre");
        @(negedge clk);
        in_read_en = 1'b1; in_type = TYPE_ROW; in_matrix = MAT_B; in_reg_address = 2'd0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ready", 32'(out_data_ready), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_host", 32'(host_rd_data), 32'd0);
        in_read_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_idle_no_pulse", 32'(out_data_ready), 32'd0);
        request(TYPE_ROW, MAT_B, 0, "t5_reissue");

        for (int n = 0; n < 120; n++) begin
            logic [1:0] t, m;
            int a;
            t = 2'($urandom_range(0, 3));
            m = 2'($urandom_range(0, 3));
            a = $urandom_range(0, DEPTH - 1);
            case ($urandom_range(0, 3))
                0: host_write(m, a, CW'($urandom));
                1: req_write(($urandom_range(0, 3) == 0) ? t : TYPE_CELL, m, a, CW'($urandom));
                2: host_read(m, a, "rnd_host_read");
                default: request(t, m, (t == TYPE_ROW) ? (a / SIZE) * SIZE : a, "rnd_req");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
